// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operation request/response bundle between the ALU front end (master)
// and the serial adder controller (slave).
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder slice; the controller time-shares a single instance
// across every operand bit.
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice, LSB first,
// sequenced IDLE -> RUN (WIDTH cycles) -> DONE with a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] sum_sr_reg, sum_sr_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;

  logic fa_sum;
  logic fa_cout;

  serial_adder_ctrl_fa u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .cout (fa_cout),
    .sum  (fa_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_sr_reg   <= a_sr_next;
      b_sr_reg   <= b_sr_next;
      sum_sr_reg <= sum_sr_next;
      carry_reg  <= carry_next;
      sum_reg    <= sum_next;
      cout_reg   <= cout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    sum_sr_next = sum_sr_reg;
    carry_next  = carry_reg;
    sum_next    = sum_reg;
    cout_next   = cout_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the carry-in is forced high.
          a_sr_next  = bus.a;
          b_sr_next  = bus.sub ? ~bus.b : bus.b;
          carry_next = bus.sub | bus.cin;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (int'(cnt_reg) >= WIDTH) begin
          state_next = S_IDLE;
        end else begin
          sum_sr_next = {fa_sum, sum_sr_reg[WIDTH-1:1]};
          a_sr_next   = a_sr_reg >> 1;
          b_sr_next   = b_sr_reg >> 1;
          carry_next  = fa_cout;
          cnt_next    = cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            // Results are published only here so sum/cout stay stable during RUN.
            sum_next   = {fa_sum, sum_sr_reg[WIDTH-1:1]};
            cout_next  = fa_cout;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign bus.done = (state_reg == S_DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized scoreboard bench for serial_adder_ctrl: the driver queues the
// arithmetic result of each accepted operation, a monitor checks every done pulse.
module tb_serial_adder_ctrl;

  localparam int W      = 8;
  localparam int MOD    = 2 ** W;
  localparam int N_RAND = 1500;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc_edge;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t         sb_q[$];
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         prev_done;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    exp_t e;
    int   r;
    if (s) begin
      r      = int'(a) - int'(b);
      e.sum  = W'((r + MOD) % MOD);
      e.cout = (a >= b);
    end else begin
      r      = int'(a) + int'(b) + int'(ci);
      e.sum  = W'(r % MOD);
      e.cout = (r >= MOD);
    end
    e.acc_edge = 0;
    e.name     = "";
    return e;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also checks output hold and return to idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sum  = '0;
      last_cout = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done)
        check("done_single_cycle_idle", !bus.done && !bus.busy, {bus.busy, bus.done}, 0);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1'b0, 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_sum"}, bus.sum == e.sum, bus.sum, e.sum);
          check({e.name, "_cout"}, bus.cout == e.cout, bus.cout, e.cout);
          check({e.name, "_latency"}, (cyc - e.acc_edge) == W, cyc - e.acc_edge, W);
          check({e.name, "_busy_in_done"}, bus.busy == 1'b1, bus.busy, 1);
          $display("op %s: sum=0x%02h cout=%0b latency=%0d", e.name, bus.sum, bus.cout,
                   cyc - e.acc_edge);
        end
        last_sum  = bus.sum;
        last_cout = bus.cout;
      end else begin
        check("result_hold", bus.sum == last_sum && bus.cout == last_cout,
              {bus.cout, bus.sum}, {last_cout, last_sum});
      end
      prev_done = bus.done;
    end
  end

  // Issue one operation from IDLE; the next edge accepts it.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic s);
    exp_t e;
    @(negedge clk);
    check({name, "_idle_before_start"}, bus.busy == 1'b0, bus.busy, 0);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.sub   = s;
    bus.start = 1'b1;
    e          = model(a, b, ci, s);
    e.acc_edge = cyc + 1;
    e.name     = name;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic wait_complete(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < 4 * W + 10) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || bus.busy) begin
      check({name, "_timeout"}, 1'b0, n, 4 * W + 10);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s);
    issue(name, a, b, ci, s);
    wait_complete(name);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", !bus.busy && !bus.done && bus.sum == '0 && !bus.cout,
          {bus.busy, bus.done, bus.cout, bus.sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1);
    run_op("sub_cin_ignored", 8'h10, 8'h10, 1'b1, 1'b1);

    // Start pulse during RUN cycle 3 must not be queued or disturb the running op.
    issue("ignored_start", 8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.a     = 8'h11;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_complete("ignored_start");
    repeat (4) @(negedge clk);

    // Abort mid-RUN via reset: outputs clear and the aborted op never completes.
    issue("aborted", 8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_outputs", !bus.busy && !bus.done && bus.sum == '0 && !bus.cout,
          {bus.busy, bus.done, bus.cout, bus.sum}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", !bus.busy && bus.sum == '0 && !bus.cout,
          {bus.busy, bus.cout, bus.sum}, 0);
    run_op("after_abort_20_03", 8'h20, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size() == 0, sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
